// File: rtl/if_id_queue.sv
// if_id_queue: fetch-to-decode buffer. A DEPTH-entry circular queue feeds a
// registered output stage; valid/ready toward fetch, level-compared hold
// toward decode, and a single-cycle flush for jumps and traps.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid_i/ready_o  fetch handshake; ready comes from registered count
//   inst_i, inst_addr_i, int_flag_i   incoming packet
//   flush_i             drop every queued, staged and incoming packet
//   hold_flag_i         output stage freezes when >= HOLD_LEVEL
//   out_valid_o, inst_o, inst_addr_o, int_flag_o   packet to decode
//   count_o             queued entries, output stage excluded
//   flush_drop_cnt_o    saturating dropped-packet counter, present only
//                       when IF_ID_QUEUE_STATS_EN is defined
module if_id_queue #(
    parameter int unsigned INST_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned INT_W      = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned HOLD_W     = 3,
    parameter int unsigned HOLD_LEVEL = 1,
    parameter logic [INST_W-1:0] NOP_INST = 32'h00000013,
    parameter logic [INT_W-1:0]  INT_NONE = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [INST_W-1:0]          inst_i,
    input  logic [ADDR_W-1:0]          inst_addr_i,
    input  logic [INT_W-1:0]           int_flag_i,
    input  logic                       flush_i,
    input  logic [HOLD_W-1:0]          hold_flag_i,
    output logic                       out_valid_o,
    output logic [INST_W-1:0]          inst_o,
    output logic [ADDR_W-1:0]          inst_addr_o,
    output logic [INT_W-1:0]           int_flag_o,
`ifdef IF_ID_QUEUE_STATS_EN
    output logic [15:0]                flush_drop_cnt_o,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [INST_W-1:0] mem_inst_q [DEPTH];
    logic [ADDR_W-1:0] mem_addr_q [DEPTH];
    logic [INT_W-1:0]  mem_int_q  [DEPTH];

    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [INT_W-1:0]  int_q, int_d;

    logic hold_en, empty, push, pop, bypass, wr_en;

    always_comb begin
        hold_en    = (32'(hold_flag_i) >= HOLD_LEVEL);
        empty      = (count_q == '0);
        in_ready_o = (count_q != CNT_W'(DEPTH));
        push       = in_valid_i & in_ready_o & ~flush_i;
        pop        = ~flush_i & ~hold_en & ~empty;
        // Empty queue and a free output stage: skip the queue entirely.
        bypass     = ~hold_en & empty & push;
        wr_en      = push & ~bypass;

        rptr_d      = rptr_q;
        wptr_d      = wptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        inst_d      = inst_q;
        addr_d      = addr_q;
        int_d       = int_q;

        if (flush_i) begin
            rptr_d      = '0;
            wptr_d      = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
            inst_d      = NOP_INST;
            addr_d      = '0;
            int_d       = INT_NONE;
        end else begin
            if (wr_en) wptr_d = wptr_q + 1'b1;
            if (pop)   rptr_d = rptr_q + 1'b1;
            count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
            if (!hold_en) begin
                if (!empty) begin
                    out_valid_d = 1'b1;
                    inst_d      = mem_inst_q[rptr_q];
                    addr_d      = mem_addr_q[rptr_q];
                    int_d       = mem_int_q[rptr_q];
                end else if (push) begin
                    out_valid_d = 1'b1;
                    inst_d      = inst_i;
                    addr_d      = inst_addr_i;
                    int_d       = int_flag_i;
                end else begin
                    out_valid_d = 1'b0;
                    inst_d      = NOP_INST;
                    addr_d      = '0;
                    int_d       = INT_NONE;
                end
            end
        end
    end

    // Storage carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_inst_q[wptr_q] <= inst_i;
            mem_addr_q[wptr_q] <= inst_addr_i;
            mem_int_q[wptr_q]  <= int_flag_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q      <= '0;
            wptr_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            inst_q      <= NOP_INST;
            addr_q      <= '0;
            int_q       <= INT_NONE;
        end else begin
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            inst_q      <= inst_d;
            addr_q      <= addr_d;
            int_q       <= int_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign inst_o      = inst_q;
    assign inst_addr_o = addr_q;
    assign int_flag_o  = int_q;
    assign count_o     = count_q;

`ifdef IF_ID_QUEUE_STATS_EN
    logic [15:0] drop_q, drop_d;
    logic [16:0] drop_sum;

    // Dropped = queued + staged + the packet fetch offered this cycle.
    always_comb begin
        drop_sum = {1'b0, drop_q} + 17'(count_q) + 17'(out_valid_q)
                 + 17'(in_valid_i & in_ready_o);
        drop_d   = drop_q;
        if (flush_i) drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) drop_q <= '0;
        else     drop_q <= drop_d;
    end

    assign flush_drop_cnt_o = drop_q;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: queue-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_if_id_queue;

    localparam int DEPTH = 4;
    localparam int HL    = 1;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [7:0]  intf;
    } pkt_t;

    localparam pkt_t NOP = '{inst: 32'h00000013, addr: 32'h0, intf: 8'h0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] inst_i = '0;
    logic [31:0] addr_i = '0;
    logic [7:0]  intf_i = '0;
    logic        flush = 1'b0;
    logic [2:0]  hold_flag = '0;
    logic        out_valid;
    logic [31:0] inst_o;
    logic [31:0] addr_o;
    logic [7:0]  intf_o;
    logic [2:0]  count;
`ifdef IF_ID_QUEUE_STATS_EN
    logic [15:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    if_id_queue #(.DEPTH(DEPTH), .HOLD_LEVEL(HL)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .inst_i      (inst_i),
        .inst_addr_i (addr_i),
        .int_flag_i  (intf_i),
        .flush_i     (flush),
        .hold_flag_i (hold_flag),
        .out_valid_o (out_valid),
        .inst_o      (inst_o),
        .inst_addr_o (addr_o),
        .int_flag_o  (intf_o),
`ifdef IF_ID_QUEUE_STATS_EN
        .flush_drop_cnt_o (drop_cnt),
`endif
        .count_o     (count)
    );

    // Reference model: accepted packets in a queue, plus the staged packet.
    pkt_t        mq[$];
    logic        m_ov = 1'b0;
    pkt_t        m_out = NOP;
    int unsigned m_drop = 0;

    int  errors = 0;
    int  checks = 0;
    bit  cmp_en = 1'b0;
    logic [31:0] next_addr = 32'h1000;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic pkt_t new_pkt();
        pkt_t p;
        p.inst = $urandom;
        p.addr = next_addr;
        p.intf = 8'($urandom_range(0, 255));
        next_addr = next_addr + 4;
        return p;
    endfunction

    task automatic present(input pkt_t p);
        inst_i = p.inst;
        addr_i = p.addr;
        intf_i = p.intf;
    endtask

    // One clock: the model takes the inputs that were stable at the edge.
    task automatic cyc(output bit acc);
        bit   rdy, hld;
        pkt_t p;
        int unsigned s;
        rdy = (mq.size() != DEPTH);
        hld = (hold_flag >= 3'(HL));
        p   = '{inst: inst_i, addr: addr_i, intf: intf_i};
        acc = 1'b0;
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            m_ov = 1'b0;
            m_out = NOP;
            m_drop = 0;
        end else if (flush) begin
            s = m_drop + mq.size() + int'(m_ov) + int'(in_valid && rdy);
            m_drop = (s > 65535) ? 65535 : s;
            mq.delete();
            m_ov = 1'b0;
            m_out = NOP;
        end else begin
            if (in_valid && rdy) begin
                mq.push_back(p);
                acc = 1'b1;
            end
            if (!hld) begin
                if (mq.size() > 0) begin
                    m_out = mq.pop_front();
                    m_ov = 1'b1;
                end else begin
                    m_out = NOP;
                    m_ov = 1'b0;
                end
            end
        end
    endtask

    task automatic cyc0();
        bit a;
        cyc(a);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("out_valid", 64'(out_valid), 64'(m_ov));
            chk("inst", 64'(inst_o), 64'(m_out.inst));
            chk("addr", 64'(addr_o), 64'(m_out.addr));
            chk("int_flag", 64'(intf_o), 64'(m_out.intf));
            chk("count", 64'(count), 64'(mq.size()));
            chk("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
`ifdef IF_ID_QUEUE_STATS_EN
            chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
`endif
        end
    end

    initial begin
        pkt_t p;
        pkt_t fa[5];
        logic [31:0] base;
        int unsigned d0;
        bit acc;
        bit fl;

        // Reset with fetch already offering a packet.
        rst = 1'b1;
        in_valid = 1'b1;
        present(new_pkt());
        cyc0();
        cmp_en = 1'b1;
        cyc0();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_inst", 64'(inst_o), 64'h13);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);

        // Bypass into an empty queue.
        p = '{inst: 32'h00500093, addr: 32'h100, intf: 8'h0};
        present(p);
        in_valid = 1'b1;
        cyc0();
        in_valid = 1'b0;
        chk("byp_valid", 64'(out_valid), 64'd1);
        chk("byp_inst", 64'(inst_o), 64'h00500093);
        chk("byp_addr", 64'(addr_o), 64'h100);
        chk("byp_count", 64'(count), 64'd0);

        // Fill under hold, E waits, then drain in order.
        hold_flag = 3'd1;
        for (int i = 0; i < 5; i++) begin
            fa[i] = '{inst: 32'hA000 + 32'(i), addr: 32'h200 + 32'(4*i),
                      intf: 8'(i)};
        end
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            present(fa[i]);
            cyc0();
        end
        chk("full_count", 64'(count), 64'd4);
        chk("full_ready", 64'(in_ready), 64'd0);
        present(fa[4]);
        cyc0();
        cyc0();
        chk("full_held", 64'(count), 64'd4);
        hold_flag = 3'd0;
        cyc0();
        chk("drain_A", 64'(addr_o), 64'h200);
        cyc0();
        chk("drain_B", 64'(addr_o), 64'h204);
        in_valid = 1'b0;
        cyc0();
        chk("drain_C", 64'(addr_o), 64'h208);
        cyc0();
        chk("drain_D", 64'(addr_o), 64'h20C);
        cyc0();
        chk("drain_E", 64'(addr_o), 64'h210);
        chk("drain_Ei", 64'(inst_o), 64'hA004);

        // Hold threshold.
        hold_flag = 3'd1;
        in_valid = 1'b1;
        base = next_addr;
        present(new_pkt());
        cyc0();
        present(new_pkt());
        cyc0();
        in_valid = 1'b0;
        hold_flag = 3'd0;
        cyc0();
        chk("thr_adv", 64'(addr_o), 64'(base));
        hold_flag = 3'd3;
        cyc0();
        chk("thr_frz3", 64'(addr_o), 64'(base));
        hold_flag = 3'd2;
        cyc0();
        chk("thr_frz2", 64'(addr_o), 64'(base));
        chk("thr_cnt", 64'(count), 64'd1);
        hold_flag = 3'd0;
        cyc0();
        chk("thr_adv2", 64'(addr_o), 64'(base + 4));

        // Flush mid-stream under hold.
        in_valid = 1'b1;
        present(new_pkt());
        cyc0();
        hold_flag = 3'd1;
        for (int i = 0; i < 3; i++) begin
            present(new_pkt());
            cyc0();
        end
        chk("pre_fl_cnt", 64'(count), 64'd3);
        chk("pre_fl_ov", 64'(out_valid), 64'd1);
        d0 = m_drop;
        present(new_pkt());
        flush = 1'b1;
        cyc0();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_count", 64'(count), 64'd0);
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_inst", 64'(inst_o), 64'h13);
`ifdef IF_ID_QUEUE_STATS_EN
        chk("fl_drop", 64'(drop_cnt), 64'(d0 + 5));
`endif
        hold_flag = 3'd0;
        for (int i = 0; i < 3; i++) begin
            cyc0();
            chk("fl_gone", 64'(out_valid), 64'd0);
        end

        // Steady state with two queued: pointers wrap, order preserved.
        hold_flag = 3'd1;
        in_valid = 1'b1;
        base = next_addr;
        present(new_pkt());
        cyc0();
        present(new_pkt());
        cyc0();
        hold_flag = 3'd0;
        for (int k = 0; k < 20; k++) begin
            present(new_pkt());
            cyc0();
            chk("wrap_cnt", 64'(count), 64'd2);
            chk("wrap_addr", 64'(addr_o), 64'(base + 32'(4*k)));
        end
        in_valid = 1'b0;

        // Randomized traffic; fetch keeps a refused packet stable.
        acc = 1'b0;
        fl = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!in_valid || acc || fl) begin
                in_valid = ($urandom_range(0, 99) < 60);
                if (in_valid) present(new_pkt());
            end
            hold_flag = ($urandom_range(0, 9) < 6) ? 3'd0
                      : 3'($urandom_range(0, 7));
            flush = ($urandom_range(0, 29) == 0);
            rst = ($urandom_range(0, 499) == 0);
            fl = flush | rst;
            cyc(acc);
        end
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        cyc0();
        cmp_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
